rggen_apb_bridge: RTL and testbench



---
 rtl/rggen_rtl_pkg.sv | 16 +
 rtl/rggen_apb_bridge_if.sv | 28 ++
 rtl/rggen_apb_timeout_counter.sv | 37 +++
 rtl/rggen_apb_bridge.sv | 141 ++++++++++++++
 tb/tb_rggen_apb_bridge.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rggen_rtl_pkg.sv
// Shared rggen bus types: transfer direction and completion status encodings.
package rggen_rtl_pkg;

  typedef enum logic {
    RGGEN_READ  = 1'b0,
    RGGEN_WRITE = 1'b1
  } rggen_direction;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

endpackage

// File: rtl/rggen_apb_bridge_if.sv
// APB4 signal bundle; the bridge uses the master view, a completer the slave view.
interface rggen_apb_bridge_if #(
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned DATA_WIDTH    = 32
);

  logic                      psel;
  logic                      penable;
  logic                      pwrite;
  logic [ADDRESS_WIDTH-1:0]  paddr;
  logic [2:0]                pprot;
  logic [DATA_WIDTH-1:0]     pwdata;
  logic [DATA_WIDTH/8-1:0]   pstrb;
  logic [DATA_WIDTH-1:0]     prdata;
  logic                      pready;
  logic                      pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pprot, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pprot, pwdata, pstrb,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/rggen_apb_timeout_counter.sv
// Counts consecutive ACCESS wait cycles; expired flags the wait cycle that hits the limit.
module rggen_apb_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_enable,
  output logic expired
);

  localparam int unsigned CountWidth = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CountWidth-1:0] LastCount = CountWidth'(TIMEOUT_CYCLES - 1);

  logic [CountWidth-1:0] count_q, count_d;

  // The limit is reached by the wait cycle that would bring the count to TIMEOUT_CYCLES.
  assign expired = count_enable && (count_q == LastCount);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable && !expired) begin
      count_d = count_q + CountWidth'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rggen_apb_bridge.sv
// APB4 initiator: converts rggen request/done transfers into APB SETUP/ACCESS phases,
// with an optional abort when the completer keeps pready low too long.
module rggen_apb_bridge
  import rggen_rtl_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter logic [2:0]  PPROT          = 3'b000,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     bus_request,
  input  logic [ADDRESS_WIDTH-1:0] bus_address,
  input  logic                     bus_direction,
  input  logic [DATA_WIDTH-1:0]    bus_write_data,
  input  logic [DATA_WIDTH/8-1:0]  bus_write_strobe,
  output logic                     bus_done,
  output logic [DATA_WIDTH-1:0]    bus_read_data,
  output logic [1:0]               bus_status,
  rggen_apb_bridge_if.master       apb
);

  localparam logic [ADDRESS_WIDTH-1:0] AddrMask = ~ADDRESS_WIDTH'((DATA_WIDTH / 8) - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

  state_e                   state_q, state_d;
  logic                     psel_q, psel_d;
  logic                     penable_q, penable_d;
  logic                     pwrite_q, pwrite_d;
  logic [ADDRESS_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]    pwdata_q, pwdata_d;
  logic [DATA_WIDTH/8-1:0]  pstrb_q, pstrb_d;
  logic                     done_q, done_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  rggen_status              status_q, status_d;
  logic                     timeout_expired;

  if (TIMEOUT_CYCLES > 0) begin : g_timeout
    rggen_apb_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_counter (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (state_q == StSetup),
      .count_enable((state_q == StAccess) && !apb.pready),
      .expired     (timeout_expired)
    );
  end else begin : g_no_timeout
    assign timeout_expired = 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    done_d    = 1'b0;
    rdata_d   = '0;
    status_d  = RGGEN_OKAY;

    unique case (state_q)
      StIdle: begin
        if (bus_request) begin
          state_d  = StSetup;
          psel_d   = 1'b1;
          pwrite_d = bus_direction;
          paddr_d  = bus_address & AddrMask;
          pwdata_d = bus_write_data;
          pstrb_d  = bus_direction ? bus_write_strobe : '0;
        end
      end
      StSetup: begin
        state_d   = StAccess;
        penable_d = 1'b1;
      end
      StAccess: begin
        // A real response in the expiring cycle takes priority over the abort.
        if (apb.pready) begin
          state_d   = StDone;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          done_d    = 1'b1;
          rdata_d   = pwrite_q ? '0 : apb.prdata;
          status_d  = apb.pslverr ? RGGEN_SLAVE_ERROR : RGGEN_OKAY;
        end else if (timeout_expired) begin
          state_d   = StDone;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          done_d    = 1'b1;
          status_d  = RGGEN_DECODE_ERROR;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      done_q    <= 1'b0;
      rdata_q   <= '0;
      status_q  <= RGGEN_OKAY;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      status_q  <= status_d;
    end
  end

  assign apb.psel      = psel_q;
  assign apb.penable   = penable_q;
  assign apb.pwrite    = pwrite_q;
  assign apb.paddr     = paddr_q;
  assign apb.pprot     = PPROT;
  assign apb.pwdata    = pwdata_q;
  assign apb.pstrb     = pstrb_q;
  assign bus_done      = done_q;
  assign bus_read_data = rdata_q;
  assign bus_status    = status_q;

endmodule

// File: tb/tb_rggen_apb_bridge.sv
// Directed bench for rggen_apb_bridge: one unbounded-wait instance and one with TIMEOUT_CYCLES=4.
module tb_rggen_apb_bridge;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          bus_request, bus_request_t;
  logic [AW-1:0] bus_address;
  logic          bus_direction;
  logic [DW-1:0] bus_write_data;
  logic [SW-1:0] bus_write_strobe;

  logic          done0, done_t;
  logic [DW-1:0] rdata0, rdata_t;
  logic [1:0]    status0, status_t;

  logic          pready0, pslverr0, pready_t, pslverr_t;
  logic [DW-1:0] prdata0, prdata_t;

  int checks   = 0;
  int failures = 0;

  rggen_apb_bridge_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) apb0 ();
  rggen_apb_bridge_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) apb_t ();

  assign apb0.pready   = pready0;
  assign apb0.pslverr  = pslverr0;
  assign apb0.prdata   = prdata0;
  assign apb_t.pready  = pready_t;
  assign apb_t.pslverr = pslverr_t;
  assign apb_t.prdata  = prdata_t;

  rggen_apb_bridge #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .PPROT         (3'b010),
    .TIMEOUT_CYCLES(0)
  ) dut0 (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus_request     (bus_request),
    .bus_address     (bus_address),
    .bus_direction   (bus_direction),
    .bus_write_data  (bus_write_data),
    .bus_write_strobe(bus_write_strobe),
    .bus_done        (done0),
    .bus_read_data   (rdata0),
    .bus_status      (status0),
    .apb             (apb0)
  );

  rggen_apb_bridge #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .PPROT         (3'b000),
    .TIMEOUT_CYCLES(4)
  ) dut_t (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus_request     (bus_request_t),
    .bus_address     (bus_address),
    .bus_direction   (bus_direction),
    .bus_write_data  (bus_write_data),
    .bus_write_strobe(bus_write_strobe),
    .bus_done        (done_t),
    .bus_read_data   (rdata_t),
    .bus_status      (status_t),
    .apb             (apb_t)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus_request = 1'b0; bus_request_t = 1'b0;
    bus_address = '0; bus_direction = 1'b0; bus_write_data = '0; bus_write_strobe = '0;
    pready0 = 1'b1; pslverr0 = 1'b0; prdata0 = '0;
    pready_t = 1'b1; pslverr_t = 1'b0; prdata_t = '0;
    #2;
    checks++;
    if ({apb0.psel, apb0.penable, apb0.pwrite, done0} !== 4'b0000) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=0000", {apb0.psel, apb0.penable, apb0.pwrite, done0});
    end
    checks++;
    if ({apb0.paddr, apb0.pwdata, apb0.pstrb, rdata0} !== '0) begin
      failures++; $display("FAIL reset_data paddr=%h pwdata=%h pstrb=%h rdata=%h exp=0",
                           apb0.paddr, apb0.pwdata, apb0.pstrb, rdata0);
    end
    checks++;
    if (status0 !== 2'b00) begin failures++; $display("FAIL reset_status got=%b exp=00", status0); end
    checks++;
    if (apb0.pprot !== 3'b010) begin failures++; $display("FAIL pprot got=%b exp=010", apb0.pprot); end
    checks++;
    if ({apb_t.psel, done_t, apb_t.pprot} !== 5'b00000) begin
      failures++; $display("FAIL reset_t got=%b exp=00000", {apb_t.psel, done_t, apb_t.pprot});
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_zero_wait();
    bus_request = 1'b1; bus_address = 16'h0013; bus_direction = 1'b1;
    bus_write_data = 32'hDEADBEEF; bus_write_strobe = 4'hF; pready0 = 1'b1;
    tick();
    checks++;
    if ({apb0.psel, apb0.penable, apb0.pwrite, done0} !== 4'b1010) begin
      failures++; $display("FAIL wr_setup_ctrl got=%b exp=1010", {apb0.psel, apb0.penable, apb0.pwrite, done0});
    end
    checks++;
    if ({apb0.paddr, apb0.pwdata, apb0.pstrb} !== {16'h0010, 32'hDEADBEEF, 4'hF}) begin
      failures++; $display("FAIL wr_setup_payload paddr=%h pwdata=%h pstrb=%h exp=0010/deadbeef/f",
                           apb0.paddr, apb0.pwdata, apb0.pstrb);
    end
    tick();
    checks++;
    if ({apb0.psel, apb0.penable, done0} !== 3'b110) begin
      failures++; $display("FAIL wr_access got=%b exp=110", {apb0.psel, apb0.penable, done0});
    end
    tick();
    checks++;
    if ({apb0.psel, apb0.penable, done0, status0, rdata0} !== {3'b001, 2'b00, 32'h0}) begin
      failures++; $display("FAIL wr_done ctrl=%b status=%b rdata=%h exp=001/00/0",
                           {apb0.psel, apb0.penable, done0}, status0, rdata0);
    end
    bus_request = 1'b0;
    tick();
    checks++;
    if ({apb0.psel, done0} !== 2'b00) begin
      failures++; $display("FAIL wr_after got=%b exp=00", {apb0.psel, done0});
    end
  endtask

  task automatic test_read_wait_states();
    bus_request = 1'b1; bus_address = 16'h0020; bus_direction = 1'b0;
    bus_write_data = 32'h11111111; bus_write_strobe = 4'hF; pready0 = 1'b0; prdata0 = '0;
    tick();
    checks++;
    if ({apb0.psel, apb0.penable, apb0.pwrite, apb0.paddr, apb0.pstrb} !== {3'b100, 16'h0020, 4'h0}) begin
      failures++; $display("FAIL rd_setup ctrl=%b paddr=%h pstrb=%h exp=100/0020/0",
                           {apb0.psel, apb0.penable, apb0.pwrite}, apb0.paddr, apb0.pstrb);
    end
    // Payload changes after acceptance must not reach the bus.
    bus_address = 16'h0044; bus_direction = 1'b1; bus_write_strobe = 4'h3;
    for (int c = 2; c <= 5; c++) begin
      tick();
      checks++;
      if ({apb0.psel, apb0.penable, apb0.pwrite, done0, apb0.paddr, apb0.pstrb} !==
          {4'b1100, 16'h0020, 4'h0}) begin
        failures++; $display("FAIL rd_access_c%0d ctrl=%b paddr=%h pstrb=%h exp=1100/0020/0", c,
                             {apb0.psel, apb0.penable, apb0.pwrite, done0}, apb0.paddr, apb0.pstrb);
      end
      if (c == 5) begin pready0 = 1'b1; prdata0 = 32'h12345678; end
    end
    tick();
    checks++;
    if ({apb0.psel, done0, status0, rdata0} !== {2'b01, 2'b00, 32'h12345678}) begin
      failures++; $display("FAIL rd_done ctrl=%b status=%b rdata=%h exp=01/00/12345678",
                           {apb0.psel, done0}, status0, rdata0);
    end
    bus_request = 1'b0;
    tick();
    checks++;
    if ({apb0.psel, done0, rdata0} !== {2'b00, 32'h0}) begin
      failures++; $display("FAIL rd_after ctrl=%b rdata=%h exp=00/0", {apb0.psel, done0}, rdata0);
    end
  endtask

  task automatic test_slave_error();
    bus_request = 1'b1; bus_address = 16'h0030; bus_direction = 1'b1;
    bus_write_data = 32'h01020304; bus_write_strobe = 4'h5;
    pready0 = 1'b1; pslverr0 = 1'b1; prdata0 = 32'h55AA55AA;
    tick();
    checks++;
    if (apb0.pstrb !== 4'h5) begin failures++; $display("FAIL err_wr_pstrb got=%h exp=5", apb0.pstrb); end
    tick(); tick();
    checks++;
    if ({done0, status0, rdata0} !== {1'b1, 2'b10, 32'h0}) begin
      failures++; $display("FAIL err_wr_done done=%b status=%b rdata=%h exp=1/10/0", done0, status0, rdata0);
    end
    bus_address = 16'h0034; bus_direction = 1'b0; prdata0 = 32'hCAFEF00D;
    tick(); tick();
    checks++;
    if ({apb0.psel, apb0.penable, apb0.pwrite, apb0.paddr} !== {3'b100, 16'h0034}) begin
      failures++; $display("FAIL err_rd_setup ctrl=%b paddr=%h exp=100/0034",
                           {apb0.psel, apb0.penable, apb0.pwrite}, apb0.paddr);
    end
    tick(); tick();
    checks++;
    if ({done0, status0, rdata0} !== {1'b1, 2'b10, 32'hCAFEF00D}) begin
      failures++; $display("FAIL err_rd_done done=%b status=%b rdata=%h exp=1/10/cafef00d", done0, status0, rdata0);
    end
    bus_request = 1'b0; pslverr0 = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    bus_request_t = 1'b1; bus_address = 16'h0050; bus_direction = 1'b0;
    pready_t = 1'b0; prdata_t = 32'hFFFF0000;
    tick();
    checks++;
    if ({apb_t.psel, apb_t.penable} !== 2'b10) begin
      failures++; $display("FAIL to_setup got=%b exp=10", {apb_t.psel, apb_t.penable});
    end
    for (int c = 2; c <= 5; c++) begin
      tick();
      checks++;
      if ({apb_t.psel, apb_t.penable, done_t} !== 3'b110) begin
        failures++; $display("FAIL to_wait_c%0d got=%b exp=110", c, {apb_t.psel, apb_t.penable, done_t});
      end
    end
    tick();
    checks++;
    if ({apb_t.psel, apb_t.penable, done_t, status_t, rdata_t} !== {3'b001, 2'b11, 32'h0}) begin
      failures++; $display("FAIL to_abort ctrl=%b status=%b rdata=%h exp=001/11/0",
                           {apb_t.psel, apb_t.penable, done_t}, status_t, rdata_t);
    end
    bus_address = 16'h0054;
    tick(); tick();
    checks++;
    if ({apb_t.psel, apb_t.paddr} !== {1'b1, 16'h0054}) begin
      failures++; $display("FAIL to2_setup psel=%b paddr=%h exp=1/0054", apb_t.psel, apb_t.paddr);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if ({apb_t.psel, apb_t.penable, done_t} !== 3'b110) begin
        failures++; $display("FAIL to2_wait_k%0d got=%b exp=110", k, {apb_t.psel, apb_t.penable, done_t});
      end
      if (k == 4) pready_t = 1'b1;
    end
    tick();
    checks++;
    if ({done_t, status_t, rdata_t} !== {1'b1, 2'b00, 32'hFFFF0000}) begin
      failures++; $display("FAIL to2_done done=%b status=%b rdata=%h exp=1/00/ffff0000", done_t, status_t, rdata_t);
    end
    bus_request_t = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic exp_psel [1:9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic exp_pen  [1:9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic exp_done [1:9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int done_count = 0;
    bus_request = 1'b1; bus_address = 16'h0004; bus_direction = 1'b1;
    bus_write_data = 32'hA5A5A5A5; bus_write_strobe = 4'hF;
    pready0 = 1'b1; pslverr0 = 1'b0; prdata0 = 32'h0BADF00D;
    for (int c = 1; c <= 9; c++) begin
      tick();
      done_count += int'(done0);
      checks++;
      if ({apb0.psel, apb0.penable, done0} !== {exp_psel[c], exp_pen[c], exp_done[c]}) begin
        failures++; $display("FAIL b2b_c%0d got=%b exp=%b", c, {apb0.psel, apb0.penable, done0},
                             {exp_psel[c], exp_pen[c], exp_done[c]});
      end
      if (c == 1) begin
        checks++;
        if ({apb0.paddr, apb0.pwrite, apb0.pwdata} !== {16'h0004, 1'b1, 32'hA5A5A5A5}) begin
          failures++; $display("FAIL b2b_wr paddr=%h pwrite=%b pwdata=%h exp=0004/1/a5a5a5a5",
                               apb0.paddr, apb0.pwrite, apb0.pwdata);
        end
      end
      if (c == 3) begin bus_address = 16'h0008; bus_direction = 1'b0; end
      if (c == 5) begin
        checks++;
        if ({apb0.paddr, apb0.pwrite, apb0.pstrb} !== {16'h0008, 1'b0, 4'h0}) begin
          failures++; $display("FAIL b2b_rd paddr=%h pwrite=%b pstrb=%h exp=0008/0/0",
                               apb0.paddr, apb0.pwrite, apb0.pstrb);
        end
      end
      if (c == 7) begin
        checks++;
        if (rdata0 !== 32'h0BADF00D) begin
          failures++; $display("FAIL b2b_rdata got=%h exp=0badf00d", rdata0);
        end
        bus_request = 1'b0;
      end
    end
    checks++;
    if (done_count != 2) begin failures++; $display("FAIL b2b_done_count got=%0d exp=2", done_count); end
  endtask

  task automatic test_reset_mid_access();
    bus_request = 1'b1; bus_address = 16'h0060; bus_direction = 1'b1;
    bus_write_data = 32'h0F0F0F0F; bus_write_strobe = 4'hC; pready0 = 1'b0;
    tick(); tick();
    // Without a timeout the bridge waits as long as the completer does.
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if ({apb0.psel, apb0.penable, done0} !== 3'b110) begin
        failures++; $display("FAIL nto_wait_c%0d got=%b exp=110", c, {apb0.psel, apb0.penable, done0});
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({apb0.psel, apb0.penable, apb0.pwrite, done0, apb0.paddr, apb0.pstrb} !== '0) begin
      failures++; $display("FAIL rst_async ctrl=%b paddr=%h pstrb=%h exp=0",
                           {apb0.psel, apb0.penable, apb0.pwrite, done0}, apb0.paddr, apb0.pstrb);
    end
    bus_request = 1'b0; pready0 = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if ({apb0.psel, apb0.penable, done0} !== 3'b000) begin
        failures++; $display("FAIL rst_idle_c%0d got=%b exp=000", c, {apb0.psel, apb0.penable, done0});
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait_states();
    test_slave_error();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
